// File: rtl/data_register_arbiter_if.sv
// Requester-side bus of the data register arbiter: host (A) and SPI engine (B).
// master = requester side, slave = arbiter side.
interface data_register_arbiter_if;
  logic        a_req;
  logic        a_we;
  logic [7:0]  a_addr;
  logic [31:0] a_wdata;
  logic        a_ack;
  logic [31:0] a_rdata;
  logic        b_req;
  logic        b_we;
  logic [7:0]  b_addr;
  logic [31:0] b_wdata;
  logic        b_ack;
  logic [31:0] b_rdata;

  modport master (
    output a_req, a_we, a_addr, a_wdata,
    output b_req, b_we, b_addr, b_wdata,
    input  a_ack, a_rdata, b_ack, b_rdata
  );

  modport slave (
    input  a_req, a_we, a_addr, a_wdata,
    input  b_req, b_we, b_addr, b_wdata,
    output a_ack, a_rdata, b_ack, b_rdata
  );
endinterface

// File: rtl/data_register_arbiter.sv
// Arbitrates host (A) and SPI engine (B) accesses onto a dual-port data register.
// Define DREG_ARB_RR_EN for round-robin contention; default build gives A fixed priority.
module data_register_arbiter (
  input  logic                          clk,
  input  logic                          rst_n,
  data_register_arbiter_if.slave        bus,
  output logic [31:0]                   dr_in1,
  output logic [31:0]                   dr_in2,
  output logic                          dr_wr1,
  output logic                          dr_wr2,
  output logic [7:0]                    dr_addr1,
  output logic [7:0]                    dr_addr2,
  output logic                          dr_hold_ctrl,
  input  logic [31:0]                   dr_out,
  output logic                          busy
);

  typedef enum logic [1:0] {IDLE, WRITE, READ_SETUP, READ_CAPTURE} state_t;

  state_t      state;
  logic        srv_b;
  logic        pend_vld;
  logic        pend_b;
`ifdef DREG_ARB_RR_EN
  logic        last_b;
`endif

  logic        paired;
  logic        serve_pend;
  logic        contend;
  logic        any_req;
  logic        grant_b;
  logic        sel_we;
  logic [7:0]  sel_addr;
  logic [31:0] sel_wdata;

  // The deferred loser of a contention is served ahead of the policy and does
  // not move the round-robin pointer, so repeated contention alternates winners.
  always_comb begin
    any_req    = bus.a_req | bus.b_req;
    paired     = bus.a_req & bus.b_req & bus.a_we & bus.b_we & (bus.a_addr != bus.b_addr);
    serve_pend = pend_vld & (pend_b ? bus.b_req : bus.a_req);
    contend    = bus.a_req & bus.b_req & ~serve_pend;
    if (serve_pend)
      grant_b = pend_b;
    else if (contend)
`ifdef DREG_ARB_RR_EN
      grant_b = ~last_b;
`else
      grant_b = 1'b0;
`endif
    else
      grant_b = bus.b_req;
    sel_we    = grant_b ? bus.b_we    : bus.a_we;
    sel_addr  = grant_b ? bus.b_addr  : bus.a_addr;
    sel_wdata = grant_b ? bus.b_wdata : bus.a_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      srv_b        <= 1'b0;
      pend_vld     <= 1'b0;
      pend_b       <= 1'b0;
`ifdef DREG_ARB_RR_EN
      last_b       <= 1'b1;
`endif
      dr_in1       <= '0;
      dr_in2       <= '0;
      dr_wr1       <= 1'b0;
      dr_wr2       <= 1'b0;
      dr_addr1     <= '0;
      dr_addr2     <= '0;
      dr_hold_ctrl <= 1'b1;
      busy         <= 1'b0;
      bus.a_ack    <= 1'b0;
      bus.b_ack    <= 1'b0;
      bus.a_rdata  <= '0;
      bus.b_rdata  <= '0;
    end else begin
      // Idle port drive unless the next state claims the port.
      dr_in1       <= '0;
      dr_in2       <= '0;
      dr_wr1       <= 1'b0;
      dr_wr2       <= 1'b0;
      dr_addr1     <= '0;
      dr_addr2     <= '0;
      dr_hold_ctrl <= 1'b1;
      busy         <= 1'b0;
      bus.a_ack    <= 1'b0;
      bus.b_ack    <= 1'b0;
      case (state)
        IDLE: begin
          pend_vld <= 1'b0;
          if (paired) begin
            state     <= WRITE;
            busy      <= 1'b1;
            dr_wr1    <= 1'b1;
            dr_addr1  <= bus.a_addr;
            dr_in1    <= bus.a_wdata;
            dr_wr2    <= 1'b1;
            dr_addr2  <= bus.b_addr;
            dr_in2    <= bus.b_wdata;
            bus.a_ack <= 1'b1;
            bus.b_ack <= 1'b1;
          end else if (any_req) begin
            srv_b <= grant_b;
            busy  <= 1'b1;
            if (contend) begin
              pend_vld <= 1'b1;
              pend_b   <= ~grant_b;
            end
`ifdef DREG_ARB_RR_EN
            if (!serve_pend)
              last_b <= grant_b;
`endif
            if (sel_we) begin
              state     <= WRITE;
              dr_wr1    <= 1'b1;
              dr_addr1  <= sel_addr;
              dr_in1    <= sel_wdata;
              bus.a_ack <= ~grant_b;
              bus.b_ack <= grant_b;
            end else begin
              state        <= READ_SETUP;
              dr_addr1     <= sel_addr;
              dr_hold_ctrl <= 1'b0;
            end
          end
        end
        WRITE: state <= IDLE;
        READ_SETUP: begin
          state <= READ_CAPTURE;
          busy  <= 1'b1;
          if (srv_b) begin
            bus.b_rdata <= dr_out;
            bus.b_ack   <= 1'b1;
          end else begin
            bus.a_rdata <= dr_out;
            bus.a_ack   <= 1'b1;
          end
        end
        READ_CAPTURE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_register_arbiter.sv
// Randomized self-checking bench for data_register_arbiter with a transaction-level reference model.
module tb_data_register_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] dr_in1, dr_in2, dr_out;
  logic        dr_wr1, dr_wr2, dr_hold_ctrl, busy;
  logic [7:0]  dr_addr1, dr_addr2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  data_register_arbiter_if bus ();

  data_register_arbiter dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .dr_in1       (dr_in1),
    .dr_in2       (dr_in2),
    .dr_wr1       (dr_wr1),
    .dr_wr2       (dr_wr2),
    .dr_addr1     (dr_addr1),
    .dr_addr2     (dr_addr2),
    .dr_hold_ctrl (dr_hold_ctrl),
    .dr_out       (dr_out),
    .busy         (busy)
  );

  // Behavioural data register fed by the DUT's ports.
  logic [31:0] mem [256];
  logic [31:0] held;
  logic        mem_clr;
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= '0;
    end else begin
      if (dr_wr1) mem[dr_addr1] <= dr_in1;
      if (dr_wr2) mem[dr_addr2] <= dr_in2;
    end
    if (!dr_hold_ctrl) held <= mem[dr_addr1];
  end
  assign dr_out = dr_hold_ctrl ? held : mem[dr_addr1];

  // Reference model state.
  logic [31:0] ref_mem [256];
`ifdef DREG_ARB_RR_EN
  bit ref_last_b;
`endif

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_reqs();
    bus.a_req = 1'b0; bus.a_we = 1'b0; bus.a_addr = '0; bus.a_wdata = '0;
    bus.b_req = 1'b0; bus.b_we = 1'b0; bus.b_addr = '0; bus.b_wdata = '0;
  endtask

  task automatic apply_reset();
    clear_reqs();
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
`ifdef DREG_ARB_RR_EN
    ref_last_b = 1'b1;
`endif
  endtask

  task automatic access(input bit we, input logic [7:0] addr, input logic [31:0] wd,
                        output logic [31:0] rd);
    rd = ref_mem[addr];
    if (we) ref_mem[addr] = wd;
  endtask

  // Expected ack cycle (relative to the request) and read data for one round.
  task automatic model_round(input bit ae, input bit aw, input logic [7:0] aa, input logic [31:0] ad,
                             input bit be, input bit bw, input logic [7:0] ba, input logic [31:0] bd,
                             output int eac, output int ebc,
                             output logic [31:0] era, output logic [31:0] erb);
    bit win_b;
    int tw;
    eac = -1; ebc = -1; era = '0; erb = '0;
    if (ae && be && aw && bw && aa != ba) begin
      eac = 1; ebc = 1;
      ref_mem[aa] = ad;
      ref_mem[ba] = bd;
    end else if (ae && be) begin
`ifdef DREG_ARB_RR_EN
      win_b = !ref_last_b;
      ref_last_b = win_b;
`else
      win_b = 1'b0;
`endif
      if (win_b) begin
        tw = bw ? 1 : 2;
        ebc = tw;
        access(bw, ba, bd, erb);
        eac = tw + 1 + (aw ? 1 : 2);
        access(aw, aa, ad, era);
      end else begin
        tw = aw ? 1 : 2;
        eac = tw;
        access(aw, aa, ad, era);
        ebc = tw + 1 + (bw ? 1 : 2);
        access(bw, ba, bd, erb);
      end
    end else if (ae) begin
      eac = aw ? 1 : 2;
      access(aw, aa, ad, era);
`ifdef DREG_ARB_RR_EN
      ref_last_b = 1'b0;
`endif
    end else if (be) begin
      ebc = bw ? 1 : 2;
      access(bw, ba, bd, erb);
`ifdef DREG_ARB_RR_EN
      ref_last_b = 1'b1;
`endif
    end
  endtask

  // Drives one round, each requester dropping req once acked; reports ack cycles.
  task automatic drive_round(input bit ae, input bit aw, input logic [7:0] aa, input logic [31:0] ad,
                             input bit be, input bit bw, input logic [7:0] ba, input logic [31:0] bd,
                             output int ac, output int bc,
                             output logic [31:0] ard, output logic [31:0] brd);
    ac = -1; bc = -1; ard = '0; brd = '0;
    bus.a_req = ae; bus.a_we = aw; bus.a_addr = aa; bus.a_wdata = ad;
    bus.b_req = be; bus.b_we = bw; bus.b_addr = ba; bus.b_wdata = bd;
    for (int c = 1; c <= 12 && ((ae && ac < 0) || (be && bc < 0)); c++) begin
      tick();
      if (bus.a_ack) begin ac = c; ard = bus.a_rdata; bus.a_req = 1'b0; end
      if (bus.b_ack) begin bc = c; brd = bus.b_rdata; bus.b_req = 1'b0; end
    end
    clear_reqs();
    tick(); tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    total++;
    if ({dr_wr1, dr_wr2, dr_hold_ctrl, bus.a_ack, bus.b_ack, busy} !== 6'b001000) begin
      bad++;
      $display("FAIL reset_ctrl: got %b want 001000",
               {dr_wr1, dr_wr2, dr_hold_ctrl, bus.a_ack, bus.b_ack, busy});
    end
    total++;
    if ({dr_addr1, dr_addr2} !== 16'h0000) begin
      bad++; $display("FAIL reset_addr: got %h want 0000", {dr_addr1, dr_addr2});
    end
    total++;
    if ({dr_in1, dr_in2} !== 64'h0) begin
      bad++; $display("FAIL reset_wdata: got %h want 0", {dr_in1, dr_in2});
    end
    total++;
    if ({bus.a_rdata, bus.b_rdata} !== 64'h0) begin
      bad++; $display("FAIL reset_rdata: got %h want 0", {bus.a_rdata, bus.b_rdata});
    end
    apply_reset();
  endtask

  task automatic test_single_write();
    bus.a_req = 1'b1; bus.a_we = 1'b1; bus.a_addr = 8'h0A; bus.a_wdata = 32'h1111ABCD;
    tick();
    total++;
    if ({dr_wr1, dr_wr2, bus.a_ack, bus.b_ack, busy} !== 5'b10101) begin
      bad++; $display("FAIL single_write_ctrl: got %b want 10101",
                      {dr_wr1, dr_wr2, bus.a_ack, bus.b_ack, busy});
    end
    total++;
    if (dr_addr1 !== 8'h0A || dr_in1 !== 32'h1111ABCD) begin
      bad++; $display("FAIL single_write_port: got %h/%h want 0a/1111abcd", dr_addr1, dr_in1);
    end
    clear_reqs();
    tick();
    total++;
    if ({dr_wr1, bus.a_ack, busy, dr_addr1} !== 11'h0) begin
      bad++; $display("FAIL single_write_release: got %h want 0", {dr_wr1, bus.a_ack, busy, dr_addr1});
    end
    ref_mem[8'h0A] = 32'h1111ABCD;
`ifdef DREG_ARB_RR_EN
    ref_last_b = 1'b0;
`endif
    tick();
  endtask

  task automatic test_paired_write();
    logic [31:0] da, db;
    da = $urandom; db = $urandom;
    bus.a_req = 1'b1; bus.a_we = 1'b1; bus.a_addr = 8'h0A; bus.a_wdata = da;
    bus.b_req = 1'b1; bus.b_we = 1'b1; bus.b_addr = 8'h2A; bus.b_wdata = db;
    tick();
    total++;
    if ({dr_wr1, dr_wr2, bus.a_ack, bus.b_ack} !== 4'hF) begin
      bad++; $display("FAIL paired_ctrl: got %b want 1111", {dr_wr1, dr_wr2, bus.a_ack, bus.b_ack});
    end
    total++;
    if ({dr_addr1, dr_addr2, dr_in1, dr_in2} !== {8'h0A, 8'h2A, da, db}) begin
      bad++; $display("FAIL paired_port: got %h want %h",
                      {dr_addr1, dr_addr2, dr_in1, dr_in2}, {8'h0A, 8'h2A, da, db});
    end
    clear_reqs();
    tick();
    total++;
    if ({dr_wr1, dr_wr2, bus.a_ack, bus.b_ack, busy} !== 5'b0) begin
      bad++; $display("FAIL paired_release: got %b want 00000",
                      {dr_wr1, dr_wr2, bus.a_ack, bus.b_ack, busy});
    end
    ref_mem[8'h0A] = da;
    ref_mem[8'h2A] = db;
    tick();
  endtask

  task automatic test_same_addr_write();
    int ac, bc, eac, ebc;
    logic [31:0] ard, brd, era, erb, da, db;
    apply_reset();
    for (int r = 0; r < 2; r++) begin
      da = $urandom; db = $urandom;
      model_round(1'b1, 1'b1, 8'h2A, da, 1'b1, 1'b1, 8'h2A, db, eac, ebc, era, erb);
      drive_round(1'b1, 1'b1, 8'h2A, da, 1'b1, 1'b1, 8'h2A, db, ac, bc, ard, brd);
      total++;
      if (ac !== eac || bc !== ebc) begin
        bad++; $display("FAIL same_addr_order r%0d: got a=%0d b=%0d want a=%0d b=%0d",
                        r, ac, bc, eac, ebc);
      end
      total++;
      if (mem[8'h2A] !== ref_mem[8'h2A]) begin
        bad++; $display("FAIL same_addr_data r%0d: got %h want %h", r, mem[8'h2A], ref_mem[8'h2A]);
      end
    end
  endtask

  task automatic test_read_b();
    int ac, bc, eac, ebc;
    logic [31:0] ard, brd, era, erb;
    model_round(1'b1, 1'b1, 8'h5A, 32'hAB11ACCC, 1'b0, 1'b0, 8'h00, 32'h0, eac, ebc, era, erb);
    drive_round(1'b1, 1'b1, 8'h5A, 32'hAB11ACCC, 1'b0, 1'b0, 8'h00, 32'h0, ac, bc, ard, brd);
    total++;
    if (ac !== eac) begin
      bad++; $display("FAIL read_b_prewrite: got ack at %0d want %0d", ac, eac);
    end
    bus.b_req = 1'b1; bus.b_we = 1'b0; bus.b_addr = 8'h5A;
    tick();
    total++;
    if ({busy, dr_hold_ctrl, bus.b_ack, dr_wr1} !== 4'b1000 || dr_addr1 !== 8'h5A) begin
      bad++; $display("FAIL read_setup: got ctrl %b addr %h want 1000 5a",
                      {busy, dr_hold_ctrl, bus.b_ack, dr_wr1}, dr_addr1);
    end
    tick();
    total++;
    if (bus.b_ack !== 1'b1 || bus.b_rdata !== 32'hAB11ACCC || dr_hold_ctrl !== 1'b1) begin
      bad++; $display("FAIL read_capture: got ack %b rdata %h hold %b want 1 ab11accc 1",
                      bus.b_ack, bus.b_rdata, dr_hold_ctrl);
    end
    clear_reqs();
    tick();
    total++;
    if (bus.b_ack !== 1'b0 || bus.b_rdata !== 32'hAB11ACCC || busy !== 1'b0) begin
      bad++; $display("FAIL read_hold: got ack %b rdata %h busy %b want 0 ab11accc 0",
                      bus.b_ack, bus.b_rdata, busy);
    end
`ifdef DREG_ARB_RR_EN
    ref_last_b = 1'b1;
`endif
    tick();
  endtask

  task automatic test_reset_mid();
    bit saw_ack;
    bus.b_req = 1'b1; bus.b_we = 1'b0; bus.b_addr = 8'h5A;
    tick();
    total++;
    if (dr_hold_ctrl !== 1'b0) begin
      bad++; $display("FAIL rst_mid_setup: got hold %b want 0", dr_hold_ctrl);
    end
    #1 rst_n = 1'b0;
    #1;
    total++;
    if ({dr_hold_ctrl, busy, bus.b_ack, dr_wr1} !== 4'b1000 || dr_addr1 !== 8'h00 ||
        bus.b_rdata !== 32'h0) begin
      bad++; $display("FAIL rst_mid_outputs: got ctrl %b addr %h rdata %h want 1000 00 0",
                      {dr_hold_ctrl, busy, bus.b_ack, dr_wr1}, dr_addr1, bus.b_rdata);
    end
    saw_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bus.b_ack || busy) saw_ack = 1'b1;
    end
    total++;
    if (saw_ack !== 1'b0) begin
      bad++; $display("FAIL rst_mid_quiet: got activity %b want 0", saw_ack);
    end
    rst_n = 1'b1;
`ifdef DREG_ARB_RR_EN
    ref_last_b = 1'b1;
`endif
    tick(); tick();
    total++;
    if (bus.b_ack !== 1'b1 || bus.b_rdata !== ref_mem[8'h5A]) begin
      bad++; $display("FAIL rst_mid_rearb: got ack %b rdata %h want 1 %h",
                      bus.b_ack, bus.b_rdata, ref_mem[8'h5A]);
    end
    clear_reqs();
    tick(); tick();
  endtask

  task automatic test_read_contention();
    int ac, bc, eac, ebc;
    logic [31:0] ard, brd, era, erb;
    logic [7:0]  aa, ba;
    for (int r = 0; r < 3; r++) begin
      aa = 8'($urandom_range(0, 7));
      ba = 8'($urandom_range(8, 15));
      model_round(1'b1, 1'b0, aa, 32'h0, 1'b1, 1'b0, ba, 32'h0, eac, ebc, era, erb);
      drive_round(1'b1, 1'b0, aa, 32'h0, 1'b1, 1'b0, ba, 32'h0, ac, bc, ard, brd);
      total++;
      if (ac !== eac || bc !== ebc) begin
        bad++; $display("FAIL read_contention_order r%0d: got a=%0d b=%0d want a=%0d b=%0d",
                        r, ac, bc, eac, ebc);
      end
      total++;
      if (ard !== era || brd !== erb) begin
        bad++; $display("FAIL read_contention_data r%0d: got %h/%h want %h/%h", r, ard, brd, era, erb);
      end
    end
  endtask

  task automatic test_random();
    int ac, bc, eac, ebc;
    logic [31:0] ard, brd, era, erb, ad, bd;
    logic [7:0]  aa, ba;
    bit ae, aw, be, bw;
    int errs;
    for (int r = 0; r < 40; r++) begin
      ae = 1'($urandom); aw = 1'($urandom); aa = 8'($urandom_range(0, 7)); ad = $urandom;
      be = 1'($urandom); bw = 1'($urandom); ba = 8'($urandom_range(0, 7)); bd = $urandom;
      model_round(ae, aw, aa, ad, be, bw, ba, bd, eac, ebc, era, erb);
      drive_round(ae, aw, aa, ad, be, bw, ba, bd, ac, bc, ard, brd);
      total++;
      if (ac !== eac || bc !== ebc) begin
        bad++; $display("FAIL random_order r%0d: got a=%0d b=%0d want a=%0d b=%0d",
                        r, ac, bc, eac, ebc);
      end
      if (ae && !aw) begin
        total++;
        if (ard !== era) begin
          bad++; $display("FAIL random_a_rdata r%0d: got %h want %h", r, ard, era);
        end
      end
      if (be && !bw) begin
        total++;
        if (brd !== erb) begin
          bad++; $display("FAIL random_b_rdata r%0d: got %h want %h", r, brd, erb);
        end
      end
    end
    errs = 0;
    for (int i = 0; i < 8; i++) if (mem[i] !== ref_mem[i]) errs++;
    total++;
    if (errs != 0) begin
      bad++; $display("FAIL random_final_mem: got %0d differing words want 0", errs);
    end
  endtask

  initial begin
    clear_reqs();
    rst_n   = 1'b0;
    mem_clr = 1'b1;
    for (int i = 0; i < 256; i++) ref_mem[i] = '0;
`ifdef DREG_ARB_RR_EN
    ref_last_b = 1'b1;
`endif
    tick(); tick();
    mem_clr = 1'b0;
    test_reset();
    test_single_write();
    test_paired_write();
    test_same_addr_write();
    test_read_b();
    test_reset_mid();
    test_read_contention();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
